// File: rtl/octree_sram_pkg.sv
// Shared types and elaboration helpers for the octree dual-port SRAM.
package octree_sram_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } sram_state_e;

  localparam logic [31:0] INIT_VAL_DEFAULT = 32'h0000_0000;

  function automatic bit rd_lat_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/octree_sram_rd_pipe.sv
// Read-return delay line: valid and data delayed RD_LAT cycles; data holds while idle.
module octree_sram_rd_pipe #(
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic [RD_LAT-1:0] v;
  logic [DW-1:0]     d [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < RD_LAT; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < RD_LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end

  assign out_valid = v[RD_LAT-1];
  assign out_data  = d[RD_LAT-1];

endmodule

// File: rtl/octree_dp_sram.sv
// True dual-port SRAM with request handshake, pipelined reads, defined
// cross-port collisions and an optional post-reset clear sweep.
module octree_dp_sram
  import octree_sram_pkg::*;
#(
  parameter int            DW         = 32,
  parameter int            DEPTH      = 1024,
  parameter int            RD_LAT     = 1,
  parameter int            RDW_NEW    = 0,
  parameter int            CLEAR_INIT = 1,
  parameter logic [DW-1:0] INIT_VAL   = DW'(INIT_VAL_DEFAULT),
  localparam int           AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req_valid,
  output logic          a_req_ready,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic [DW-1:0] a_wmask,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req_valid,
  output logic          b_req_ready,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  input  logic [DW-1:0] b_wmask,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          init_busy,
  output logic          collision,
  output logic          addr_err
);

  if (!rd_lat_legal(RD_LAT) || DEPTH < 2) begin : g_param_check
    $error("octree_dp_sram: RD_LAT must be 1 or 2 and DEPTH at least 2");
  end

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];

  sram_state_e   state;
  logic [AW-1:0] init_cnt;
  logic          init_we;
  logic          run;

  logic a_acc, b_acc, a_in, b_in, a_wr, b_wr, a_rd, b_rd, same;
  logic [DW-1:0] a_old, b_old, a_merged, b_merged, both_word;
  logic [DW-1:0] a_rd_word, b_rd_word;

  assign run         = (state == S_RUN);
  assign init_we     = (state == S_INIT) && (CLEAR_INIT != 0);
  assign init_busy   = init_we;
  assign a_req_ready = run;
  assign b_req_ready = run;

  // Without CLEAR_INIT the FSM still spends one cycle in INIT so ready is low out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else if (state == S_INIT) begin
      if ((CLEAR_INIT == 0) || (init_cnt == LAST_IDX)) begin
        state    <= S_RUN;
        init_cnt <= '0;
      end else begin
        init_cnt <= init_cnt + AW'(1);
      end
    end
  end

  assign a_acc = a_req_valid & run;
  assign b_acc = b_req_valid & run;
  assign a_in  = {1'b0, a_addr} < DEPTH_W;
  assign b_in  = {1'b0, b_addr} < DEPTH_W;
  assign a_wr  = a_acc & a_we & a_in;
  assign b_wr  = b_acc & b_we & b_in;
  assign a_rd  = a_acc & ~a_we;
  assign b_rd  = b_acc & ~b_we;
  assign same  = (a_addr == b_addr);

  assign a_old     = a_in ? mem[a_addr] : '0;
  assign b_old     = b_in ? mem[b_addr] : '0;
  assign a_merged  = (a_old & ~a_wmask) | (a_wdata & a_wmask);
  assign b_merged  = (b_old & ~b_wmask) | (b_wdata & b_wmask);
  // Same-word double write: A owns its masked bits, B fills only bits A leaves alone.
  assign both_word = (a_old & ~(a_wmask | b_wmask)) | (a_wdata & a_wmask)
                   | (b_wdata & b_wmask & ~a_wmask);

  assign a_rd_word = ((RDW_NEW != 0) && b_wr && same) ? b_merged : a_old;
  assign b_rd_word = ((RDW_NEW != 0) && a_wr && same) ? a_merged : b_old;

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt] <= INIT_VAL;
    end else if (a_wr && b_wr && same) begin
      mem[a_addr] <= both_word;
    end else begin
      if (a_wr) mem[a_addr] <= a_merged;
      if (b_wr) mem[b_addr] <= b_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      collision <= a_acc & b_acc & a_in & b_in & same & (a_we | b_we);
      addr_err  <= (a_acc & ~a_in) | (b_acc & ~b_in);
    end
  end

  octree_sram_rd_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_a_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_rd),
    .in_data   (a_rd_word),
    .out_valid (a_rvalid),
    .out_data  (a_rdata)
  );

  octree_sram_rd_pipe #(.DW(DW), .RD_LAT(RD_LAT)) u_b_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_rd),
    .in_data   (b_rd_word),
    .out_valid (b_rvalid),
    .out_data  (b_rdata)
  );

endmodule

// File: tb/tb_octree_dp_sram.sv
// Bench: two SRAM configurations driven by shared stimulus, checked against a word-level model.
module tb_octree_dp_sram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_req_valid, a_we, b_req_valid, b_we;
  logic [9:0]  a_addr, b_addr;
  logic [31:0] a_wdata, a_wmask, b_wdata, b_wmask;

  logic        a_req_ready_0, b_req_ready_0, a_rvalid_0, b_rvalid_0;
  logic        init_busy_0, collision_0, addr_err_0;
  logic [31:0] a_rdata_0, b_rdata_0;
  logic        a_req_ready_1, b_req_ready_1, a_rvalid_1, b_rvalid_1;
  logic        init_busy_1, collision_1, addr_err_1;
  logic [31:0] a_rdata_1, b_rdata_1;

  octree_dp_sram #(.DW(32), .DEPTH(1024), .RD_LAT(1), .RDW_NEW(0), .CLEAR_INIT(1),
                   .INIT_VAL(32'h0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready_0), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_wmask(a_wmask), .a_rvalid(a_rvalid_0), .a_rdata(a_rdata_0),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready_0), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_wmask(b_wmask), .b_rvalid(b_rvalid_0), .b_rdata(b_rdata_0),
    .init_busy(init_busy_0), .collision(collision_0), .addr_err(addr_err_0)
  );

  octree_dp_sram #(.DW(32), .DEPTH(1000), .RD_LAT(2), .RDW_NEW(1), .CLEAR_INIT(1),
                   .INIT_VAL(32'h0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready_1), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_wmask(a_wmask), .a_rvalid(a_rvalid_1), .a_rdata(a_rdata_1),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready_1), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_wmask(b_wmask), .b_rvalid(b_rvalid_1), .b_rdata(b_rdata_1),
    .init_busy(init_busy_1), .collision(collision_1), .addr_err(addr_err_1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, got, exp);
    end
  endtask

  // ---------------- reference model (word arrays + due-cycle schedule) ----------------
  logic [31:0] mm [2][1024];
  int          init_left [2];
  logic        ev [2][2][4];
  logic [31:0] ed [2][2][4];
  logic        ecol [2][4];
  logic        eerr [2][4];
  logic [31:0] last [2][2];
  int          cyc = 0;
  bit          chk_en = 1'b0;

  function automatic int dep_of(input int d); return (d == 0) ? 1024 : 1000; endfunction
  function automatic int lat_of(input int d); return (d == 0) ? 1 : 2; endfunction
  function automatic bit rdw_of(input int d); return d == 1; endfunction

  task automatic model_step(input int d, input logic [1:0] rdy, input logic busy,
                            input logic av, input logic [31:0] ad,
                            input logic bv, input logic [31:0] bd,
                            input logic col, input logic err);
    int s, sl, dep;
    logic r, aacc, bacc, ain, bin;
    logic [31:0] pre_a, pre_b, post_a, post_b;
    s = cyc % 4;
    dep = dep_of(d);
    if (!rst_n) begin
      chk($sformatf("d%0d_rst_ready@%0d", d, cyc), rdy, 2'b00);
      chk($sformatf("d%0d_rst_busy@%0d", d, cyc), busy, 1'b1);
      chk($sformatf("d%0d_rst_a_rvalid@%0d", d, cyc), av, 1'b0);
      chk($sformatf("d%0d_rst_b_rvalid@%0d", d, cyc), bv, 1'b0);
      chk($sformatf("d%0d_rst_a_rdata@%0d", d, cyc), ad, 32'h0);
      chk($sformatf("d%0d_rst_b_rdata@%0d", d, cyc), bd, 32'h0);
      chk($sformatf("d%0d_rst_collision@%0d", d, cyc), col, 1'b0);
      chk($sformatf("d%0d_rst_addr_err@%0d", d, cyc), err, 1'b0);
      for (int i = 0; i < 4; i++) begin
        ev[d][0][i] = 1'b0; ev[d][1][i] = 1'b0; ecol[d][i] = 1'b0; eerr[d][i] = 1'b0;
      end
      last[d][0] = 32'h0; last[d][1] = 32'h0;
      init_left[d] = dep;
      for (int i = 0; i < 1024; i++) mm[d][i] = 32'h0;
      return;
    end
    r = (init_left[d] == 0);
    chk($sformatf("d%0d_ready@%0d", d, cyc), rdy, r ? 2'b11 : 2'b00);
    chk($sformatf("d%0d_busy@%0d", d, cyc), busy, !r);
    chk($sformatf("d%0d_a_rvalid@%0d", d, cyc), av, ev[d][0][s]);
    if (ev[d][0][s]) last[d][0] = ed[d][0][s];
    chk($sformatf("d%0d_a_rdata@%0d", d, cyc), ad, last[d][0]);
    chk($sformatf("d%0d_b_rvalid@%0d", d, cyc), bv, ev[d][1][s]);
    if (ev[d][1][s]) last[d][1] = ed[d][1][s];
    chk($sformatf("d%0d_b_rdata@%0d", d, cyc), bd, last[d][1]);
    chk($sformatf("d%0d_collision@%0d", d, cyc), col, ecol[d][s]);
    chk($sformatf("d%0d_addr_err@%0d", d, cyc), err, eerr[d][s]);
    ev[d][0][s] = 1'b0; ev[d][1][s] = 1'b0; ecol[d][s] = 1'b0; eerr[d][s] = 1'b0;

    // the upcoming edge: reads see the word before any write, writes apply B then A (A wins)
    aacc = a_req_valid && r;
    bacc = b_req_valid && r;
    ain  = int'(a_addr) < dep;
    bin  = int'(b_addr) < dep;
    pre_a = ain ? mm[d][a_addr] : 32'h0;
    pre_b = bin ? mm[d][b_addr] : 32'h0;
    if (bacc && b_we && bin) mm[d][b_addr] = (mm[d][b_addr] & ~b_wmask) | (b_wdata & b_wmask);
    if (aacc && a_we && ain) mm[d][a_addr] = (mm[d][a_addr] & ~a_wmask) | (a_wdata & a_wmask);
    post_a = ain ? mm[d][a_addr] : 32'h0;
    post_b = bin ? mm[d][b_addr] : 32'h0;
    sl = (cyc + lat_of(d)) % 4;
    if (aacc && !a_we) begin ev[d][0][sl] = 1'b1; ed[d][0][sl] = rdw_of(d) ? post_a : pre_a; end
    if (bacc && !b_we) begin ev[d][1][sl] = 1'b1; ed[d][1][sl] = rdw_of(d) ? post_b : pre_b; end
    ecol[d][(cyc+1)%4] = aacc && bacc && ain && bin && (a_addr == b_addr) && (a_we || b_we);
    eerr[d][(cyc+1)%4] = (aacc && !ain) || (bacc && !bin);
    if (init_left[d] > 0) init_left[d]--;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      model_step(0, {a_req_ready_0, b_req_ready_0}, init_busy_0, a_rvalid_0, a_rdata_0,
                 b_rvalid_0, b_rdata_0, collision_0, addr_err_0);
      model_step(1, {a_req_ready_1, b_req_ready_1}, init_busy_1, a_rvalid_1, a_rdata_1,
                 b_rvalid_1, b_rdata_1, collision_1, addr_err_1);
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic        v;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [31:0] wm;
  } port_t;

  typedef struct {
    port_t       a;
    port_t       b;
    logic        ea;
    logic [31:0] ead;
    logic        eb;
    logic [31:0] ebd;
    logic        ecol;
  } vec_t;

  function automatic port_t nop();
    port_t p; p.v = 1'b0; p.we = 1'b0; p.addr = '0; p.wd = '0; p.wm = '0; return p;
  endfunction
  function automatic port_t rd(input int addr);
    port_t p; p = nop(); p.v = 1'b1; p.addr = 10'(addr); return p;
  endfunction
  function automatic port_t wr(input int addr, input logic [31:0] wd, input logic [31:0] wm);
    port_t p; p = rd(addr); p.we = 1'b1; p.wd = wd; p.wm = wm; return p;
  endfunction
  function automatic vec_t mkv(input port_t a, input port_t b, input logic ea,
                               input logic [31:0] ead, input logic eb,
                               input logic [31:0] ebd, input logic ecol);
    vec_t t; t.a = a; t.b = b; t.ea = ea; t.ead = ead; t.eb = eb; t.ebd = ebd; t.ecol = ecol;
    return t;
  endfunction
  function automatic logic [31:0] wpat(input int i);
    return {8'hC0, 8'(i), 16'hBEEF};
  endfunction

  task automatic drive(input port_t pa, input port_t pb);
    a_req_valid = pa.v; a_we = pa.we; a_addr = pa.addr; a_wdata = pa.wd; a_wmask = pa.wm;
    b_req_valid = pb.v; b_we = pb.we; b_addr = pb.addr; b_wdata = pb.wd; b_wmask = pb.wm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic port_t rnd_port();
    port_t p;
    int r;
    p.v  = ($urandom_range(0, 3) != 0);
    p.we = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 9);
    if (r < 7)      p.addr = 10'($urandom_range(0, 7));
    else if (r < 9) p.addr = 10'($urandom_range(0, 1023));
    else            p.addr = 10'($urandom_range(995, 1023));
    p.wd = $urandom;
    p.wm = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom;
    return p;
  endfunction

  vec_t tbl [12];

  initial begin
    int busy0, busy1, na, nb, ia, ib, nv;
    tbl[0]  = mkv(rd(3), rd(1023), 1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
    tbl[1]  = mkv(wr(5, 32'hDEAD_BEEF, 32'hFFFF_0000), nop(), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tbl[2]  = mkv(rd(5), nop(), 1'b1, 32'hDEAD_0000, 1'b0, 32'h0, 1'b0);
    tbl[3]  = mkv(wr(7, 32'h1111_1111, 32'hFFFF_FFFF), wr(7, 32'h2222_2222, 32'hFFFF_FFFF),
                  1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tbl[4]  = mkv(rd(7), nop(), 1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
    tbl[5]  = mkv(wr(7, 32'h1111_1111, 32'h0000_FFFF), wr(7, 32'h2222_2222, 32'hFFFF_FFFF),
                  1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tbl[6]  = mkv(nop(), rd(7), 1'b0, 32'h0, 1'b1, 32'h2222_1111, 1'b0);
    tbl[7]  = mkv(wr(9, 32'hA, 32'hFFFF_FFFF), nop(), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tbl[8]  = mkv(wr(9, 32'hB, 32'hFFFF_FFFF), rd(9), 1'b0, 32'h0, 1'b1, 32'hA, 1'b1);
    tbl[9]  = mkv(rd(9), rd(9), 1'b1, 32'hB, 1'b1, 32'hB, 1'b0);
    tbl[10] = mkv(rd(1000), wr(1000, 32'h55, 32'hFFFF_FFFF), 1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
    tbl[11] = mkv(rd(1000), nop(), 1'b1, 32'h55, 1'b0, 32'h0, 1'b0);

    rst_n = 1'b1;
    drive(nop(), nop());
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // clear sweep length on both configurations
    busy0 = 0; busy1 = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (init_busy_1) busy1++;
      if (init_busy_0) busy0++;
      else break;
    end
    chk("init_len_d0", busy0, 1024);
    chk("init_len_d1", busy1, 1000);
    chk("ready_after_init_d0", {a_req_ready_0, b_req_ready_0}, 2'b11);

    step();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].a, tbl[i].b);
      step();
      chk($sformatf("tbl%0d_a_rvalid", i), a_rvalid_0, tbl[i].ea);
      if (tbl[i].ea) chk($sformatf("tbl%0d_a_rdata", i), a_rdata_0, tbl[i].ead);
      chk($sformatf("tbl%0d_b_rvalid", i), b_rvalid_0, tbl[i].eb);
      if (tbl[i].eb) chk($sformatf("tbl%0d_b_rdata", i), b_rdata_0, tbl[i].ebd);
      chk($sformatf("tbl%0d_collision", i), collision_0, tbl[i].ecol);
    end
    drive(nop(), nop());
    step();

    // back-to-back reads on the two-cycle configuration
    for (int i = 0; i < 16; i++) begin
      drive(wr(i, wpat(i), 32'hFFFF_FFFF), nop());
      step();
    end
    na = 0; nb = 0; ia = 0; ib = 0;
    for (int k = 0; k < 20; k++) begin
      if (k < 16) drive(rd(k), rd(15 - k));
      else        drive(nop(), nop());
      step();
      if (a_rvalid_1) begin
        na++;
        if (ia < 16) chk($sformatf("burst_a_data%0d", ia), a_rdata_1, wpat(ia));
        ia++;
      end
      if (b_rvalid_1) begin
        nb++;
        if (ib < 16) chk($sformatf("burst_b_data%0d", ib), b_rdata_1, wpat(15 - ib));
        ib++;
      end
    end
    chk("burst_a_count", na, 16);
    chk("burst_b_count", nb, 16);

    // out-of-range read on DEPTH=1000, in range on DEPTH=1024
    drive(rd(1000), nop());
    step();
    drive(nop(), nop());
    chk("oor_addr_err_d1", addr_err_1, 1'b1);
    chk("oor_addr_err_d0", addr_err_0, 1'b0);
    chk("oor_rdata_d0", a_rdata_0, 32'h55);
    step();
    chk("oor_rvalid_d1", a_rvalid_1, 1'b1);
    chk("oor_rdata_d1", a_rdata_1, 32'h0);
    step();

    for (int i = 0; i < 1500; i++) begin
      drive(rnd_port(), rnd_port());
      step();
    end

    // reset in the middle of a read burst
    for (int i = 0; i < 3; i++) begin
      drive(rd(i), rd(i + 1));
      step();
    end
    rst_n = 1'b0;
    drive(nop(), nop());
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      nv += int'(a_rvalid_0) + int'(b_rvalid_0) + int'(a_rvalid_1) + int'(b_rvalid_1);
    end
    chk("midrst_rvalid_count", nv, 0);
    chk("midrst_busy", {init_busy_0, init_busy_1}, 2'b11);
    rst_n = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      step();
      if (a_req_ready_0 && a_req_ready_1) break;
    end
    chk("reinit_ready", {a_req_ready_0, a_req_ready_1}, 2'b11);
    drive(rd(5), rd(999));
    step();
    drive(nop(), nop());
    chk("reinit_rdata_a", a_rdata_0, 32'h0);
    chk("reinit_rdata_b", b_rdata_0, 32'h0);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
